// File: rtl/card_match_ctrl.sv
// Purpose: memory-game controller; reveals clicked cards, compares picture IDs, locks pairs or flips them back.
// Latency: accepted click in cycle t shows face_up in t+1; match/mismatch resolved one cycle after the second reveal.
// Backpressure: none; clicks arriving while busy, done, out of range or on visible cards are dropped silently.
// Option: define CARD_FAST_HIDE_EN to let any in-range click cut the mismatch hide delay short.
module card_match_ctrl #(
  parameter int N_CARDS    = 8,
  parameter int ID_W       = 3,
  parameter int HIDE_DELAY = 65_000_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    click_valid,
  input  logic [3:0]              click_idx,
  input  logic [N_CARDS*ID_W-1:0] card_ids,
  output logic [N_CARDS-1:0]      face_up,
  output logic [N_CARDS-1:0]      matched,
  output logic [3:0]              pairs_found,
  output logic                    busy,
  output logic                    game_done
);

  localparam int IDX_W = $clog2(N_CARDS);
  localparam int CNT_W = $clog2(HIDE_DELAY + 1);

  localparam logic [3:0]       PAIRS_ALL = 4'(N_CARDS / 2);
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(HIDE_DELAY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ONE,
    S_CHECK,
    S_WAIT_HIDE,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     first_q, first_d;
  logic [IDX_W-1:0]     second_q, second_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [N_CARDS-1:0]   face_up_q, face_up_d;
  logic [N_CARDS-1:0]   matched_q, matched_d;
  logic [3:0]           pairs_q, pairs_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 idx_in_range;
  logic [IDX_W-1:0]     click_sel;
  logic                 card_free;
  logic                 click_ok;
  logic [ID_W-1:0]      id_of [N_CARDS];
  logic                 ids_equal;
  logic [3:0]           pairs_inc;
  logic                 hide_now;

  // Qualify the click: in range, and the target card is neither shown nor locked.
  always_comb begin
    idx_in_range = ({1'b0, click_idx} < 5'(N_CARDS));
    click_sel    = click_idx[IDX_W-1:0];
    card_free    = 1'b0;
    if (idx_in_range) begin
      card_free = ~face_up_q[click_sel] & ~matched_q[click_sel];
    end
    click_ok = click_valid & card_free;
  end

  // Unpack the per-card picture IDs and compare the two revealed cards.
  always_comb begin
    for (int k = 0; k < N_CARDS; k++) begin
      id_of[k] = card_ids[k*ID_W +: ID_W];
    end
    ids_equal = (id_of[first_q] == id_of[second_q]);
    pairs_inc = pairs_q + 4'd1;
  end

  // Decide when a mismatched pair flips back: counter expiry, or optionally an early click.
  always_comb begin
    hide_now = (cnt_q == '0);
`ifdef CARD_FAST_HIDE_EN
    if (click_valid && idx_in_range) begin
      hide_now = 1'b1;
    end
`endif
  end

  // Game FSM next-state and datapath updates.
  always_comb begin
    state_d   = state_q;
    first_d   = first_q;
    second_d  = second_q;
    cnt_d     = cnt_q;
    face_up_d = face_up_q;
    matched_d = matched_q;
    pairs_d   = pairs_q;

    case (state_q)
      S_IDLE: begin
        if (click_ok) begin
          face_up_d[click_sel] = 1'b1;
          first_d              = click_sel;
          state_d              = S_ONE;
        end
      end

      S_ONE: begin
        // A click on the first card fails card_free because it is already face-up.
        if (click_ok) begin
          face_up_d[click_sel] = 1'b1;
          second_d             = click_sel;
          state_d              = S_CHECK;
        end
      end

      S_CHECK: begin
        if (ids_equal) begin
          matched_d[first_q]  = 1'b1;
          matched_d[second_q] = 1'b1;
          pairs_d             = pairs_inc;
          state_d             = (pairs_inc == PAIRS_ALL) ? S_DONE : S_IDLE;
        end else begin
          cnt_d   = CNT_LOAD;
          state_d = S_WAIT_HIDE;
        end
      end

      S_WAIT_HIDE: begin
        if (hide_now) begin
          face_up_d[first_q]  = 1'b0;
          face_up_d[second_q] = 1'b0;
          cnt_d               = '0;
          state_d             = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      S_DONE: begin
        state_d = S_DONE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status flags are computed from the next state so they can be registered alongside it.
  always_comb begin
    busy_d = (state_d == S_CHECK) || (state_d == S_WAIT_HIDE);
    done_d = (state_d == S_DONE);
  end

  // State and output registers; reset aborts any pending hide and clears the board.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      first_q   <= '0;
      second_q  <= '0;
      cnt_q     <= '0;
      face_up_q <= '0;
      matched_q <= '0;
      pairs_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      first_q   <= first_d;
      second_q  <= second_d;
      cnt_q     <= cnt_d;
      face_up_q <= face_up_d;
      matched_q <= matched_d;
      pairs_q   <= pairs_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign face_up     = face_up_q;
  assign matched     = matched_q;
  assign pairs_found = pairs_q;
  assign busy        = busy_q;
  assign game_done   = done_q;

endmodule

// File: tb/tb_card_match_ctrl.sv
// Bench for card_match_ctrl: 4 cards, IDs {1,0,1,0} (card3..card0), hide delay 4.
// A per-cycle reference model pushes expected outputs into a queue as each input is driven;
// the entry is popped and compared once the DUT has clocked that input.
module tb_card_match_ctrl;

  localparam int N   = 4;
  localparam int IDW = 3;
  localparam int HD  = 4;

  localparam int P_IDLE  = 0;
  localparam int P_ONE   = 1;
  localparam int P_CHECK = 2;
  localparam int P_WAIT  = 3;
  localparam int P_DONE  = 4;

`ifdef CARD_FAST_HIDE_EN
  localparam int EXP_BUSY = 2;
  localparam int EXP_TAIL = 0;
`else
  localparam int EXP_BUSY = 5;
  localparam int EXP_TAIL = 2;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             click_valid = 1'b0;
  logic [3:0]       click_idx = 4'd0;
  logic [N*IDW-1:0] card_ids;
  logic [N-1:0]     face_up;
  logic [N-1:0]     matched;
  logic [3:0]       pairs_found;
  logic             busy;
  logic             game_done;

  int ids [N] = '{0, 1, 0, 1};
  assign card_ids = {3'd1, 3'd0, 3'd1, 3'd0};

  always #5 clk = ~clk;

  card_match_ctrl #(
    .N_CARDS   (N),
    .ID_W      (IDW),
    .HIDE_DELAY(HD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .click_valid(click_valid),
    .click_idx  (click_idx),
    .card_ids   (card_ids),
    .face_up    (face_up),
    .matched    (matched),
    .pairs_found(pairs_found),
    .busy       (busy),
    .game_done  (game_done)
  );

  typedef struct {
    logic [3:0] face;
    logic [3:0] match;
    logic [3:0] pairs;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;

  logic [3:0] m_face, m_match, m_pairs;
  int         m_phase, m_first, m_second, m_left;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_face = 4'd0; m_match = 4'd0; m_pairs = 4'd0;
    m_phase = P_IDLE; m_first = 0; m_second = 0; m_left = 0;
  endtask

  task automatic model_step(input logic v, input logic [3:0] idx);
    bit take;
    bit cut;
    take = 1'b0;
    cut  = 1'b0;
    if (v && idx < N) take = !m_face[idx[1:0]] && !m_match[idx[1:0]];
    case (m_phase)
      P_IDLE: if (take) begin m_face[idx[1:0]] = 1'b1; m_first = int'(idx); m_phase = P_ONE; end
      P_ONE:  if (take) begin m_face[idx[1:0]] = 1'b1; m_second = int'(idx); m_phase = P_CHECK; end
      P_CHECK: begin
        if (ids[m_first] == ids[m_second]) begin
          m_match[m_first]  = 1'b1;
          m_match[m_second] = 1'b1;
          m_pairs++;
          m_phase = (m_pairs == N / 2) ? P_DONE : P_IDLE;
        end else begin
          m_left  = HD - 1;
          m_phase = P_WAIT;
        end
      end
      P_WAIT: begin
        cut = (m_left == 0);
`ifdef CARD_FAST_HIDE_EN
        if (v && idx < N) cut = 1'b1;
`endif
        if (cut) begin
          m_face[m_first]  = 1'b0;
          m_face[m_second] = 1'b0;
          m_phase = P_IDLE;
        end else begin
          m_left--;
        end
      end
      default: ;
    endcase
  endtask

  task automatic push_exp();
    exp_t e;
    e.face  = m_face;
    e.match = m_match;
    e.pairs = m_pairs;
    e.busy  = (m_phase == P_CHECK) || (m_phase == P_WAIT);
    e.done  = (m_phase == P_DONE);
    sb.push_back(e);
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("sb_face_up",     face_up,     e.face);
      chk("sb_matched",     matched,     e.match);
      chk("sb_pairs_found", pairs_found, e.pairs);
      chk("sb_busy",        busy,        e.busy);
      chk("sb_game_done",   game_done,   e.done);
    end
  endtask

  task automatic step(input logic v, input logic [3:0] idx);
    click_valid = v;
    click_idx   = idx;
    model_step(v, idx);
    push_exp();
    @(posedge clk);
    #1;
    click_valid = 1'b0;
    click_idx   = 4'd0;
    compare_out();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    click_valid = 1'b0;
    click_idx   = 4'd0;
    model_reset();
    push_exp();
    @(posedge clk);
    #1;
    compare_out();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bl;
    int wl;

    // Reset and idle
    do_reset();
    chk("rst_face_up", face_up, 4'b0000);
    chk("rst_pairs", pairs_found, 4'd0);
    chk("rst_done", game_done, 1'b0);
    step(1'b0, 4'd0);
    step(1'b0, 4'd0);

    // Out-of-range click
    step(1'b1, 4'd5);
    chk("oor_face_up", face_up, 4'b0000);
    chk("oor_busy", busy, 1'b0);

    // Mismatch (1,2) with clicks on card 3 while busy
    step(1'b1, 4'd1);
    chk("mm_face_first", face_up, 4'b0010);
    step(1'b1, 4'd2);
    chk("mm_face_pair", face_up, 4'b0110);
    chk("mm_busy_check", busy, 1'b1);
    bl = 0;
    for (int i = 0; i < 20; i++) begin
      if (!busy) break;
      bl++;
      step(1'b1, 4'd3);
    end
    chk("mm_busy_len", bl, EXP_BUSY);
    chk("mm_hidden", face_up, 4'b0000);
    chk("mm_busy_end", busy, 1'b0);

    // Re-click the same card, then match (0,2)
    step(1'b1, 4'd0);
    chk("m_face_first", face_up, 4'b0001);
    step(1'b1, 4'd0);
    chk("reclick_face", face_up, 4'b0001);
    chk("reclick_busy", busy, 1'b0);
    step(1'b1, 4'd2);
    chk("m_face_pair", face_up, 4'b0101);
    chk("m_busy_check", busy, 1'b1);
    step(1'b0, 4'd0);
    chk("m_matched", matched, 4'b0101);
    chk("m_pairs", pairs_found, 4'd1);
    chk("m_busy_one_cycle", busy, 1'b0);

    // Clicks on locked cards are dropped
    step(1'b1, 4'd0);
    step(1'b1, 4'd2);
    chk("locked_pairs", pairs_found, 4'd1);
    chk("locked_face", face_up, 4'b0101);

    // Second pair (1,3) completes the game
    step(1'b1, 4'd1);
    step(1'b1, 4'd3);
    chk("c_face_all", face_up, 4'b1111);
    step(1'b0, 4'd0);
    chk("c_pairs", pairs_found, 4'd2);
    chk("c_done", game_done, 1'b1);
    chk("c_matched", matched, 4'b1111);
    chk("c_busy", busy, 1'b0);
    step(1'b1, 4'd1);
    step(1'b1, 4'd0);
    chk("c_done_hold", game_done, 1'b1);
    chk("c_face_hold", face_up, 4'b1111);

    // Reset clears a finished game
    do_reset();
    chk("rst2_face_up", face_up, 4'b0000);
    chk("rst2_matched", matched, 4'b0000);
    chk("rst2_pairs", pairs_found, 4'd0);
    chk("rst2_done", game_done, 1'b0);

    // Early click in the second wait cycle
    step(1'b1, 4'd1);
    step(1'b1, 4'd2);
    step(1'b0, 4'd0);
    step(1'b0, 4'd0);
    chk("fh_busy_wait2", busy, 1'b1);
    step(1'b1, 4'd3);
`ifdef CARD_FAST_HIDE_EN
    chk("fh_face_cut", face_up, 4'b0000);
    chk("fh_busy_cut", busy, 1'b0);
`else
    chk("fh_face_held", face_up, 4'b0110);
    chk("fh_busy_held", busy, 1'b1);
`endif
    wl = 0;
    for (int i = 0; i < 20; i++) begin
      if (!busy) break;
      wl++;
      step(1'b0, 4'd0);
    end
    chk("fh_tail_len", wl, EXP_TAIL);
    chk("fh_face_end", face_up, 4'b0000);
    chk("fh_card3_hidden", face_up[3], 1'b0);

    step(1'b0, 4'd0);
    step(1'b0, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
